// File: rtl/rmt_pkg.sv
// rtl/rmt_pkg.sv - shared header offsets, match constants and state encoding for the packet filter
package rmt_pkg;

   localparam int TPID_OFF      = 12;
   localparam int ETYPE_OFF     = 16;
   localparam int IPPROTO_OFF   = 27;
   localparam int UDP_DPORT_OFF = 40;

   localparam logic [15:0] TPID_VLAN   = 16'h8100;
   localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  IPPROTO_UDP = 8'h11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FWD_DATA = 2'd1,
      FWD_CTRL = 2'd2,
      DROP     = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_DATA = 2'd0,
      CLS_CTRL = 2'd1,
      CLS_DROP = 2'd2
   } cls_t;

   // Header fields are big-endian on the wire: the lower byte index is the MSB.
   function automatic logic [15:0] hdr16(input logic [511:0] d, input int off);
      return {d[8*off +: 8], d[8*(off+1) +: 8]};
   endfunction

   function automatic cls_t classify(input logic [511:0] d, input logic [15:0] ctrl_port);
      if (hdr16(d, TPID_OFF) != TPID_VLAN || hdr16(d, ETYPE_OFF) != ETYPE_IPV4)
         return CLS_DROP;
      if (d[8*IPPROTO_OFF +: 8] == IPPROTO_UDP && hdr16(d, UDP_DPORT_OFF) == ctrl_port)
         return CLS_CTRL;
      return CLS_DATA;
   endfunction

endpackage

// File: rtl/rmt_axis_out_reg.sv
// rtl/rmt_axis_out_reg.sv - single-stage AXI-Stream output register with load/free handshake
module rmt_axis_out_reg #(
   parameter int DATA_W = 512,
   parameter int USER_W = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_W-1:0]     in_tdata,
   input  logic [DATA_W/8-1:0]   in_tkeep,
   input  logic [USER_W-1:0]     in_tuser,
   input  logic                  in_tlast,
   output logic                  free,
   output logic [DATA_W-1:0]     m_tdata,
   output logic [DATA_W/8-1:0]   m_tkeep,
   output logic [USER_W-1:0]     m_tuser,
   output logic                  m_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready
);

   // A new beat may be loaded whenever the held beat leaves on this same edge.
   assign free = ~m_tvalid | m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tuser  <= '0;
         m_tlast  <= 1'b0;
      end else if (load) begin
         m_tvalid <= 1'b1;
         m_tdata  <= in_tdata;
         m_tkeep  <= in_tkeep;
         m_tuser  <= in_tuser;
         m_tlast  <= in_tlast;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/rmt_pkt_filter.sv
// rtl/rmt_pkt_filter.sv - first-beat classifier steering packets to data, control or drop
module rmt_pkt_filter
   import rmt_pkg::*;
#(
   parameter int          C_S_AXIS_DATA_WIDTH  = 512,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
   parameter int          CNT_WIDTH            = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                                 s_axis_tvalid,
   input  logic                                 s_axis_tlast,
   output logic                                 s_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                                 m_axis_tvalid,
   output logic                                 m_axis_tlast,
   input  logic                                 m_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
   output logic                                 c_m_axis_tvalid,
   output logic                                 c_m_axis_tlast,
   input  logic                                 c_m_axis_tready,

   output logic [CNT_WIDTH-1:0]                 cnt_data,
   output logic [CNT_WIDTH-1:0]                 cnt_ctrl,
   output logic [CNT_WIDTH-1:0]                 cnt_drop
);

   state_t state_q, state_d;
   cls_t   first_cls, beat_cls;
   logic   m_free, c_free;
   logic   accept, first_beat;
   logic   load_data, load_ctrl;

   assign first_cls = classify(s_axis_tdata, CTRL_UDP_PORT);

   always_comb begin
      state_d       = state_q;
      s_axis_tready = 1'b0;
      beat_cls      = CLS_DROP;
      load_data     = 1'b0;
      load_ctrl     = 1'b0;
      accept        = 1'b0;

      // In IDLE the destination is unknown until the beat is classified, so both outputs must be free.
      case (state_q)
         IDLE: begin
            s_axis_tready = m_free & c_free;
            beat_cls      = first_cls;
         end
         FWD_DATA: begin
            s_axis_tready = m_free;
            beat_cls      = CLS_DATA;
         end
         FWD_CTRL: begin
            s_axis_tready = c_free;
            beat_cls      = CLS_CTRL;
         end
         DROP: begin
            s_axis_tready = 1'b1;
            beat_cls      = CLS_DROP;
         end
         default: begin
            s_axis_tready = 1'b0;
            beat_cls      = CLS_DROP;
         end
      endcase

      if (rst)
         s_axis_tready = 1'b0;

      accept = s_axis_tvalid & s_axis_tready;

      if (accept) begin
         load_data = (beat_cls == CLS_DATA);
         load_ctrl = (beat_cls == CLS_CTRL);
         if (s_axis_tlast) begin
            state_d = IDLE;
         end else if (state_q == IDLE) begin
            case (first_cls)
               CLS_DATA: state_d = FWD_DATA;
               CLS_CTRL: state_d = FWD_CTRL;
               default:  state_d = DROP;
            endcase
         end
      end
   end

   assign first_beat = accept & (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Counters wrap naturally at 2^CNT_WIDTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_data <= '0;
         cnt_ctrl <= '0;
         cnt_drop <= '0;
      end else if (first_beat) begin
         case (first_cls)
            CLS_DATA: cnt_data <= cnt_data + 1'b1;
            CLS_CTRL: cnt_ctrl <= cnt_ctrl + 1'b1;
            default:  cnt_drop <= cnt_drop + 1'b1;
         endcase
      end
   end

   rmt_axis_out_reg #(
      .DATA_W (C_S_AXIS_DATA_WIDTH),
      .USER_W (C_S_AXIS_TUSER_WIDTH)
   ) u_data_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (load_data),
      .in_tdata (s_axis_tdata),
      .in_tkeep (s_axis_tkeep),
      .in_tuser (s_axis_tuser),
      .in_tlast (s_axis_tlast),
      .free     (m_free),
      .m_tdata  (m_axis_tdata),
      .m_tkeep  (m_axis_tkeep),
      .m_tuser  (m_axis_tuser),
      .m_tlast  (m_axis_tlast),
      .m_tvalid (m_axis_tvalid),
      .m_tready (m_axis_tready)
   );

   rmt_axis_out_reg #(
      .DATA_W (C_S_AXIS_DATA_WIDTH),
      .USER_W (C_S_AXIS_TUSER_WIDTH)
   ) u_ctrl_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (load_ctrl),
      .in_tdata (s_axis_tdata),
      .in_tkeep (s_axis_tkeep),
      .in_tuser (s_axis_tuser),
      .in_tlast (s_axis_tlast),
      .free     (c_free),
      .m_tdata  (c_m_axis_tdata),
      .m_tkeep  (c_m_axis_tkeep),
      .m_tuser  (c_m_axis_tuser),
      .m_tlast  (c_m_axis_tlast),
      .m_tvalid (c_m_axis_tvalid),
      .m_tready (c_m_axis_tready)
   );

endmodule

// File: tb/tb_rmt_pkt_filter.sv
// tb/tb_rmt_pkt_filter.sv - randomized scoreboard bench for rmt_pkt_filter
module tb_rmt_pkt_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [511:0]  s_axis_tdata;
   logic [63:0]   s_axis_tkeep;
   logic [127:0]  s_axis_tuser;
   logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [511:0]  m_axis_tdata, c_m_axis_tdata;
   logic [63:0]   m_axis_tkeep, c_m_axis_tkeep;
   logic [127:0]  m_axis_tuser, c_m_axis_tuser;
   logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic          c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tready;
   logic [31:0]   cnt_data, cnt_ctrl, cnt_drop;

   rmt_pkt_filter dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tuser(c_m_axis_tuser),
      .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast), .c_m_axis_tready(c_m_axis_tready),
      .cnt_data(cnt_data), .cnt_ctrl(cnt_ctrl), .cnt_drop(cnt_drop)
   );

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic [127:0] u;
      logic         l;
   } beat_t;

   beat_t q_data[$];
   beat_t q_ctrl[$];
   int    exp_data, exp_ctrl, exp_drop;
   int    n_pass = 0, n_total = 0;
   int    cur_dest = 2;
   bit    m_bp_rand = 0, c_bp_rand = 0, m_force_low = 0, exp_rdy_one = 0;

   task automatic chk(input bit ok, input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
   endtask

   // Reference: byte n of the beat is tdata[8n+7:8n]; 0 = data, 1 = control, 2 = drop.
   function automatic int ref_class(input logic [511:0] d);
      logic [7:0] b[64];
      for (int i = 0; i < 64; i++) b[i] = d[8*i +: 8];
      if (!(b[12] == 8'h81 && b[13] == 8'h00 && b[16] == 8'h08 && b[17] == 8'h00)) return 2;
      if (b[27] == 8'h11 && b[40] == 8'hf1 && b[41] == 8'hf2) return 1;
      return 0;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // kind: 0 ctrl, 1 UDP other port, 2 IPv4 non-UDP, 3 untagged, 4 tagged non-IPv4
   function automatic logic [511:0] make_first(input int kind, input logic [15:0] port);
      logic [511:0] d;
      logic [7:0]   p;
      d = rand512();
      d[8*12 +: 8] = 8'h81; d[8*13 +: 8] = 8'h00;
      d[8*16 +: 8] = 8'h08; d[8*17 +: 8] = 8'h00;
      d[8*27 +: 8] = 8'h11;
      d[8*40 +: 8] = 8'hf1; d[8*41 +: 8] = 8'hf2;
      case (kind)
         1: begin
            if (port == 16'hf1f2) port = 16'h1300;
            d[8*40 +: 8] = port[15:8]; d[8*41 +: 8] = port[7:0];
         end
         2: begin
            p = 8'($urandom_range(255));
            if (p == 8'h11) p = 8'h06;
            d[8*27 +: 8] = p;
         end
         3: begin d[8*12 +: 8] = 8'h08; d[8*13 +: 8] = 8'h00; end
         4: begin d[8*16 +: 8] = 8'h86; d[8*17 +: 8] = 8'hdd; end
         default: ;
      endcase
      return d;
   endfunction

   initial begin
      m_axis_tready = 1'b1;
      c_m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #2;
         m_axis_tready   = m_force_low ? 1'b0 : (m_bp_rand ? ($urandom_range(3) != 0) : 1'b1);
         c_m_axis_tready = c_bp_rand ? ($urandom_range(3) != 0) : 1'b1;
      end
   end

   task automatic drive_beat(input beat_t b, input int dest);
      int  budget;
      bit  done;
      s_axis_tdata = b.d; s_axis_tkeep = b.k; s_axis_tuser = b.u; s_axis_tlast = b.l;
      cur_dest = dest;
      s_axis_tvalid = 1'b1;
      done = 0; budget = 0;
      while (!done) begin
         @(negedge clk);
         if (exp_rdy_one) chk(s_axis_tready == 1'b1, "drop_tready", 512'(s_axis_tready), 512'(1));
         if (s_axis_tready) done = 1;
         @(posedge clk); #1;
         budget++;
         if (!done && budget > 300) begin
            chk(1'b0, "accept_timeout", 512'(budget), 512'(300));
            done = 1;
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input logic [511:0] first, input int nb, input logic [127:0] u0,
                           input logic [63:0] lkeep, input bit gaps);
      beat_t bs[$];
      beat_t b;
      int    c;
      c = ref_class(first);
      if (c == 0) exp_data++; else if (c == 1) exp_ctrl++; else exp_drop++;
      for (int i = 0; i < nb; i++) begin
         b.d = (i == 0) ? first : rand512();
         b.k = (i == nb - 1) ? lkeep : 64'hffff_ffff_ffff_ffff;
         b.u = (i == 0) ? u0 : rand128();
         b.l = (i == nb - 1);
         bs.push_back(b);
         if (c == 0) q_data.push_back(b);
         else if (c == 1) q_ctrl.push_back(b);
      end
      foreach (bs[i]) begin
         if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
         end
         drive_beat(bs[i], c);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_data.size() != 0 || q_ctrl.size() != 0 || m_axis_tvalid || c_m_axis_tvalid) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk(n < 400, "drain_timeout", 512'(n), 512'(400));
   endtask

   task automatic chk_counters(input string tag);
      chk(cnt_data == 32'(exp_data), {tag, "_cnt_data"}, 512'(cnt_data), 512'(exp_data));
      chk(cnt_ctrl == 32'(exp_ctrl), {tag, "_cnt_ctrl"}, 512'(cnt_ctrl), 512'(exp_ctrl));
      chk(cnt_drop == 32'(exp_drop), {tag, "_cnt_drop"}, 512'(cnt_drop), 512'(exp_drop));
   endtask

   // Monitor: pops the scoreboard on every output handshake, checks 1-cycle latency and hold stability.
   initial begin
      bit    pend_acc, m_stall, c_stall;
      int    pend_dest;
      beat_t m_held, c_held, act, exp;
      pend_acc = 0; m_stall = 0; c_stall = 0; pend_dest = 2;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend_acc = 0; m_stall = 0; c_stall = 0;
         end else begin
            if (pend_acc && pend_dest == 0)
               chk(m_axis_tvalid, "latency_data", 512'(m_axis_tvalid), 512'(1));
            if (pend_acc && pend_dest == 1)
               chk(c_m_axis_tvalid, "latency_ctrl", 512'(c_m_axis_tvalid), 512'(1));
            pend_acc  = s_axis_tvalid && s_axis_tready;
            pend_dest = cur_dest;

            act = '{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            if (m_stall)
               chk(m_axis_tvalid && act == m_held, "data_hold", act.d, m_held.d);
            if (m_axis_tvalid && m_axis_tready) begin
               if (q_data.size() == 0) chk(1'b0, "data_unexpected", act.d, 512'(0));
               else begin
                  exp = q_data.pop_front();
                  chk(act == exp, "data_beat", act.d ^ exp.d, {exp.k, exp.u, 7'd0, exp.l});
               end
            end
            m_stall = m_axis_tvalid && !m_axis_tready;
            m_held  = act;

            act = '{c_m_axis_tdata, c_m_axis_tkeep, c_m_axis_tuser, c_m_axis_tlast};
            if (c_stall)
               chk(c_m_axis_tvalid && act == c_held, "ctrl_hold", act.d, c_held.d);
            if (c_m_axis_tvalid && c_m_axis_tready) begin
               if (q_ctrl.size() == 0) chk(1'b0, "ctrl_unexpected", act.d, 512'(0));
               else begin
                  exp = q_ctrl.pop_front();
                  chk(act == exp, "ctrl_beat", act.d ^ exp.d, {exp.k, exp.u, 7'd0, exp.l});
               end
            end
            c_stall = c_m_axis_tvalid && !c_m_axis_tready;
            c_held  = act;
         end
      end
   end

   initial begin
      beat_t b;
      rst = 1'b1;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
      exp_data = 0; exp_ctrl = 0; exp_drop = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(s_axis_tready == 1'b0, "rst_tready", 512'(s_axis_tready), 512'(0));
      chk(!m_axis_tvalid && !c_m_axis_tvalid, "rst_tvalid", 512'({m_axis_tvalid, c_m_axis_tvalid}), 512'(0));
      chk(m_axis_tdata == '0 && c_m_axis_tdata == '0, "rst_tdata", m_axis_tdata | c_m_axis_tdata, 512'(0));
      chk_counters("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // two-beat control packet
      send_pkt(make_first(0, 16'h0), 2, 128'h10042, 64'h3, 0);
      drain();
      chk_counters("ctrl2");

      // single-beat data packet, dport 0x1300
      send_pkt(make_first(1, 16'h1300), 1, rand128(), 64'hffff_ffff_ffff_ffff, 0);
      drain();
      chk_counters("data1");

      // untagged packet is dropped with tready held high
      exp_rdy_one = 1;
      send_pkt(make_first(3, 16'h0), 3, rand128(), 64'h0f, 0);
      exp_rdy_one = 0;
      repeat (2) begin @(posedge clk); #1; end
      chk(!m_axis_tvalid && !c_m_axis_tvalid, "drop_no_out", 512'({m_axis_tvalid, c_m_axis_tvalid}), 512'(0));
      chk_counters("drop");

      // backpressure on the data output for 5 cycles
      m_force_low = 1;
      fork
         send_pkt(make_first(2, 16'h0), 3, rand128(), 64'hff, 0);
         begin
            repeat (5) @(negedge clk);
            chk(s_axis_tready == 1'b0, "bp_tready", 512'(s_axis_tready), 512'(0));
            chk(m_axis_tvalid == 1'b1, "bp_tvalid", 512'(m_axis_tvalid), 512'(1));
            m_force_low = 0;
         end
      join
      drain();
      chk_counters("bp");

      // control packet directly followed by data packet
      send_pkt(make_first(0, 16'h0), 2, rand128(), 64'h1, 0);
      send_pkt(make_first(1, 16'($urandom())), 2, rand128(), 64'h7, 0);
      drain();
      chk_counters("b2b");

      // randomized traffic with random backpressure and input gaps
      m_bp_rand = 1; c_bp_rand = 1;
      for (int i = 0; i < 40; i++)
         send_pkt(make_first($urandom_range(4), 16'($urandom())), $urandom_range(1, 4),
                  rand128(), 64'($urandom_range(1, 255)), 1'($urandom_range(1)));
      m_bp_rand = 0; c_bp_rand = 0;
      drain();
      chk_counters("rand");

      // reset mid-packet with a beat stuck in the data output
      m_force_low = 1;
      b = '{make_first(1, 16'h2222), 64'hffff_ffff_ffff_ffff, rand128(), 1'b0};
      q_data.push_back(b);
      exp_data++;
      drive_beat(b, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_force_low = 0;
      q_data.delete();
      exp_data = 0; exp_ctrl = 0; exp_drop = 0;
      @(negedge clk);
      chk(!m_axis_tvalid && !c_m_axis_tvalid, "midrst_tvalid", 512'({m_axis_tvalid, c_m_axis_tvalid}), 512'(0));
      chk_counters("midrst");
      @(posedge clk); #1;
      send_pkt(make_first(0, 16'h0), 2, rand128(), 64'h3, 0);
      drain();
      chk_counters("post_rst");

      chk(q_data.size() == 0, "data_queue_empty", 512'(q_data.size()), 512'(0));
      chk(q_ctrl.size() == 0, "ctrl_queue_empty", 512'(q_ctrl.size()), 512'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rmt_pkt_filter.md
Name: rmt_pkt_filter

Overview:
- Ingress stage placed directly upstream of rmt_wrapper on the 512-bit AXI-Stream path.
- Inspects the first beat of every packet and classifies it:
  - VLAN-tagged IPv4/UDP packets whose UDP destination port equals CTRL_UDP_PORT go to the control output.
  - Other VLAN-tagged IPv4 packets go to the data output, which feeds rmt_wrapper.
  - All remaining packets are dropped.
- Keeps per-class packet counters for status readout.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, stream data width; only 512 is supported.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; tuser is carried unchanged.
- CTRL_UDP_PORT, 16'hf1f2, UDP destination port that marks control packets.
- CNT_WIDTH, 32, width of each packet counter.

Ports:
- clk  in  1  stream clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  512/64/128/1/1  ingress stream
- s_axis_tready  out  1  ingress backpressure
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  data stream to rmt_wrapper
- m_axis_tready  in  1
- c_m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  control stream
- c_m_axis_tready  in  1
- cnt_data, cnt_ctrl, cnt_drop  out  CNT_WIDTH each  packet counters

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values:
  - All tvalid outputs = 0; all counters = 0; state = IDLE.
  - Output data, keep, user and last registers = 0.
  - s_axis_tready = 0 while rst is high, then it follows the rule below.
- Header fields (byte n = tdata[8n+7:8n]) and checks:
  - TPID, bytes 12–13 = 81 00.
  - Ethertype, bytes 16–17 = 08 00.
  - IP protocol, byte 27 = 0x11.
  - UDP dst port = {byte40, byte41}.
- Classification, combinational on a first beat accepted in IDLE:
  - TPID or ethertype mismatch → DROP.
  - Otherwise, protocol == 0x11 and port == CTRL_UDP_PORT → CTRL.
  - Otherwise → DATA.
- State machine (IDLE, FWD_DATA, FWD_CTRL, DROP); a transition happens only on an accepted beat (s_axis_tvalid & s_axis_tready):
  - IDLE + accepted first beat:
    - If tlast = 1, stay in IDLE; the beat is still forwarded or dropped and the matching counter increments.
    - Otherwise go to FWD_DATA, FWD_CTRL or DROP.
  - FWD_*/DROP + accepted beat with tlast = 1 → IDLE.
  - A beat with tlast = 0 stays in the current state.
- Output register, one per destination (single stage):
  - Accepted beats are registered into the selected output. Latency is exactly 1 cycle from acceptance to tvalid.
  - The non-selected output's tvalid stays 0.
- Handshake:
  - In IDLE, s_axis_tready = (~m_axis_tvalid | m_axis_tready) & (~c_m_axis_tvalid | c_m_axis_tready). Both outputs must be free because the destination is not yet known.
  - In FWD_DATA, s_axis_tready = ~m_axis_tvalid | m_axis_tready. FWD_CTRL uses the same rule on the c_m_axis side.
  - In DROP, s_axis_tready = 1; beats are discarded.
  - Output tvalid clears on tready when no new beat is loaded. Valid and data hold stable while tready is low.
- Counters increment by 1 once per packet, on acceptance of its first beat:
  - cnt_data, cnt_ctrl or cnt_drop according to the classification.
  - Counters wrap from 2^CNT_WIDTH-1 to 0.
- Boundaries:
  - Back-to-back packets (tlast followed by a new first beat next cycle) need no idle gap.
  - tvalid low mid-packet holds the current state.
  - rst mid-packet returns to IDLE and clears outputs. The next beat seen is treated as a first beat; the team accepts that tail beats are then misclassified.
  - tuser is forwarded on every beat unchanged.

Decomposition:
- Shared package rmt_pkg holds:
  - header byte offsets: TPID_OFF = 12, ETYPE_OFF = 16, IPPROTO_OFF = 27, UDP_DPORT_OFF = 40;
  - the constants 16'h8100, 16'h0800, 8'h11;
  - the state encoding.
- One natural sub-module, rmt_axis_out_reg: a single-stage AXIS register (valid/ready, data/keep/user/last), instantiated twice, once for the data output and once for the control output.

Test Plan:
- Two-beat VLAN/IPv4/UDP packet with dport f1f2 (first beat ...f2f1d204..., tuser 0x10042); second beat tkeep 0x3 → appears on c_m_axis 1 cycle after each accepted beat; m_axis_tvalid stays 0; cnt_ctrl = 1.
- Single-beat IPv4 packet with tlast = 1 and dport 0x1300 → m_axis carries an identical beat with tkeep 0xffff_ffff_ffff_ffff; state remains IDLE; cnt_data = 1.
- Packet with TPID bytes 08 00 (untagged) → neither output valid; s_axis_tready stays 1 throughout; cnt_drop = 1.
- m_axis_tready low for 5 cycles during a 3-beat data packet → s_axis_tready low; output beat held stable; no beat lost or duplicated; tlast delivered once.
- Ctrl packet immediately followed by a data packet → ordering preserved per output; counters ctrl = 1, data = 1.
- rst asserted mid-packet for 1 cycle → all tvalid = 0 and counters = 0 next cycle; a following clean packet is classified correctly.
